// File: rtl/memory_pipe_responder.sv
// Memory pipe responder: queues arbiter requests, issues them to backing memory,
// and returns read data / store acks in order. Define MEMORY_PIPE_RESPONDER_MMU_FLAGS_EN to return MMU flags.
module memory_pipe_responder #(
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iREQ_VALID,
  output logic        oREQ_LOCK,
  input  logic        iREQ_STORE_ACK,
  input  logic [1:0]  iREQ_MMU_MODE,
  input  logic [2:0]  iREQ_MMU_PS,
  input  logic [1:0]  iREQ_ORDER,
  input  logic [3:0]  iREQ_MASK,
  input  logic        iREQ_RW,
  input  logic [31:0] iREQ_ADDR,
  input  logic [31:0] iREQ_DATA,
  output logic        oRESP_VALID,
  input  logic        iRESP_BUSY,
  output logic        oRESP_STORE_ACK,
  output logic [63:0] oRESP_DATA,
  output logic [23:0] oRESP_MMU_FLAGS,
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic        oMEM_RW,
  output logic [3:0]  oMEM_MASK,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  output logic        oMEM_BUSY,
  input  logic [63:0] iMEM_DATA
);

  typedef struct packed {
    logic        storeAck;
    logic [1:0]  mmuMode;
    logic [2:0]  mmuPs;
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

`ifdef MEMORY_PIPE_RESPONDER_MMU_FLAGS_EN
  typedef struct packed {
    logic       rw;
    logic       storeAck;
    logic [1:0] mmuMode;
    logic [2:0] mmuPs;
  } tag_t;
`else
  typedef struct packed {
    logic rw;
    logic storeAck;
  } tag_t;
`endif

  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_HOLD  = 1'b1
  } resp_state_t;

  localparam logic [P_DEPTH_N:0]   LP_FULL = (P_DEPTH_N + 1)'(P_DEPTH);
  localparam logic [P_DEPTH_N-1:0] LP_LAST = P_DEPTH_N'(P_DEPTH - 1);

  cmd_t                 r_cmdMem [P_DEPTH];
  tag_t                 r_pendMem [P_DEPTH];
  logic [P_DEPTH_N-1:0] r_cmdWr, r_cmdRd, r_pendWr, r_pendRd;
  logic [P_DEPTH_N:0]   r_cmdCount, r_pendCount;
  resp_state_t          r_respState;
  logic                 r_respStoreAck;
  logic [63:0]          r_respData;

  cmd_t w_cmdIn, w_cmdHead;
  tag_t w_tagIn, w_pendHead;
  logic w_reqPush, w_cmdPop, w_pendPop, w_respLoad;

  function automatic logic [P_DEPTH_N-1:0] f_nextPtr(input logic [P_DEPTH_N-1:0] ptr);
    return (ptr == LP_LAST) ? '0 : ptr + 1'b1;
  endfunction

  // Lock looks only at the registered count, so a same-cycle pop never lets a request in at full.
  assign oREQ_LOCK  = (r_cmdCount == LP_FULL);
  assign w_reqPush  = iREQ_VALID && !oREQ_LOCK;
  assign w_cmdHead  = r_cmdMem[r_cmdRd];
  assign oMEM_REQ   = (r_cmdCount != '0) && (r_pendCount != LP_FULL);
  assign w_cmdPop   = oMEM_REQ && !iMEM_LOCK;
  assign oMEM_RW    = w_cmdHead.rw;
  assign oMEM_MASK  = w_cmdHead.mask;
  assign oMEM_ADDR  = w_cmdHead.addr;
  assign oMEM_DATA  = w_cmdHead.data;

  assign w_cmdIn = '{storeAck: iREQ_STORE_ACK, mmuMode: iREQ_MMU_MODE, mmuPs: iREQ_MMU_PS,
                     order: iREQ_ORDER, mask: iREQ_MASK, rw: iREQ_RW,
                     addr: iREQ_ADDR, data: iREQ_DATA};

`ifdef MEMORY_PIPE_RESPONDER_MMU_FLAGS_EN
  assign w_tagIn = '{rw: w_cmdHead.rw, storeAck: w_cmdHead.storeAck,
                     mmuMode: w_cmdHead.mmuMode, mmuPs: w_cmdHead.mmuPs};
`else
  assign w_tagIn = '{rw: w_cmdHead.rw, storeAck: w_cmdHead.storeAck};
`endif

  assign oMEM_BUSY   = (r_respState == RESP_HOLD) && iRESP_BUSY;
  assign w_pendHead  = r_pendMem[r_pendRd];
  assign w_pendPop   = iMEM_VALID && !oMEM_BUSY && (r_pendCount != '0);
  assign w_respLoad  = w_pendPop && (!w_pendHead.rw || w_pendHead.storeAck);

  assign oRESP_VALID     = (r_respState == RESP_HOLD);
  assign oRESP_STORE_ACK = r_respStoreAck;
  assign oRESP_DATA      = r_respData;

  always_ff @(posedge iCLOCK) begin
    if (w_reqPush) r_cmdMem[r_cmdWr] <= w_cmdIn;
    if (w_cmdPop)  r_pendMem[r_pendWr] <= w_tagIn;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_cmdWr     <= '0;
      r_cmdRd     <= '0;
      r_cmdCount  <= '0;
      r_pendWr    <= '0;
      r_pendRd    <= '0;
      r_pendCount <= '0;
    end else begin
      if (w_reqPush) r_cmdWr  <= f_nextPtr(r_cmdWr);
      if (w_cmdPop)  r_cmdRd  <= f_nextPtr(r_cmdRd);
      if (w_cmdPop)  r_pendWr <= f_nextPtr(r_pendWr);
      if (w_pendPop) r_pendRd <= f_nextPtr(r_pendRd);
      case ({w_reqPush, w_cmdPop})
        2'b10:   r_cmdCount <= r_cmdCount + 1'b1;
        2'b01:   r_cmdCount <= r_cmdCount - 1'b1;
        default: r_cmdCount <= r_cmdCount;
      endcase
      case ({w_cmdPop, w_pendPop})
        2'b10:   r_pendCount <= r_pendCount + 1'b1;
        2'b01:   r_pendCount <= r_pendCount - 1'b1;
        default: r_pendCount <= r_pendCount;
      endcase
    end
  end

  // A completion popped while the old response leaves reloads the register back-to-back.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_respState    <= RESP_EMPTY;
      r_respStoreAck <= 1'b0;
      r_respData     <= '0;
    end else if (w_respLoad) begin
      r_respState    <= RESP_HOLD;
      r_respStoreAck <= w_pendHead.rw;
      r_respData     <= w_pendHead.rw ? 64'h0 : iMEM_DATA;
    end else if ((r_respState == RESP_HOLD) && !iRESP_BUSY) begin
      r_respState    <= RESP_EMPTY;
    end
  end

`ifdef MEMORY_PIPE_RESPONDER_MMU_FLAGS_EN
  logic [23:0] r_respFlags;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_respFlags <= '0;
    end else if (w_respLoad) begin
      r_respFlags <= {19'h0, w_pendHead.mmuPs, w_pendHead.mmuMode};
    end
  end

  assign oRESP_MMU_FLAGS = r_respFlags;
`else
  assign oRESP_MMU_FLAGS = 24'h0;
`endif

endmodule
